range_monitor: RTL and testbench
================================

RANGE_MONITOR -- requirements
Module: range_monitor

Interface
REQ-001 Parameter WIDTH, 16, signed sample width; declared with value range from [2:32].
REQ-002 Parameter CHANNELS, 4, independent channels; value range from [1:16].
REQ-003 Parameter LO, -100, inclusive lower bound; value range from [-(2**(WIDTH-1)) : HI].
REQ-004 Parameter HI, 100, inclusive upper bound.
REQ-005 Parameter EX_LO, 10, start of excluded window, inclusive.
REQ-006 Parameter EX_HI, 20, end of excluded window, exclusive; EX_LO == EX_HI means no exclusion.
REQ-007 Parameter THRESH, 3, consecutive violations to alarm; value range from [1:15].
REQ-008 Parameter CLEAR, 2, consecutive in-range samples to leave alarm; value range from [1:15].
REQ-009 Parameter CNT_W, 8, violation counter width; value range from [2:16].
REQ-010 clk  input  1  clock; all state changes on the rising edge.
REQ-011 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-012 in_valid  input  CHANNELS  per-channel sample strobe.
REQ-013 in_data  input  CHANNELS*WIDTH  signed samples; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-014 clr  input  1  synchronous clear of all counters and states.
REQ-015 rd_sel  input  max(1,$clog2(CHANNELS))  counter readout select.
REQ-016 rd_count  output  CNT_W  violation count of channel rd_sel.
REQ-017 viol  output  CHANNELS  registered one-cycle violation pulse.
REQ-018 alarm  output  CHANNELS  per-channel alarm level.
REQ-019 any_alarm  output  1  OR of alarm.

Function
REQ-020 A sample x is in range iff LO <= x <= HI and not (EX_LO <= x < EX_HI), using signed comparison.
REQ-021 A violation is a valid sample (in_valid[i]=1) that is not in range; viol[i] asserts on the edge after the sample edge for exactly one cycle (latency 1).
REQ-022 Each channel has a violation counter that increments on each violation and saturates at 2**CNT_W-1 with no wrap.
REQ-023 Each channel has an FSM with states OK, WARN and ALARM; alarm[i]=1 only in ALARM, and the alarm level is registered.
REQ-024 In OK, a violation moves the FSM to WARN with bad_run=1, or directly to ALARM when THRESH==1; an in-range sample keeps it in OK.
REQ-025 In WARN, a violation increments bad_run and moves to ALARM when bad_run reaches THRESH; an in-range sample returns to OK with bad_run=0.
REQ-026 In ALARM, an in-range sample increments good_run and moves to OK when good_run reaches CLEAR; a violation zeroes good_run and stays in ALARM.
REQ-027 Cycles with in_valid[i]=0 hold all channel-i state, counters and runs.
REQ-028 clr=1 forces all FSMs to OK, zeroes runs and counters, and suppresses viol on the next cycle; clr takes priority over a simultaneous in_valid.
REQ-029 rd_count is combinational from the selected counter; an rd_sel value >= CHANNELS returns 0.
REQ-030 Channels are fully independent, and simultaneous valid samples on all channels are processed in the same cycle.
REQ-031 any_alarm is registered in the same edge as alarm and has no extra latency.

Reset
REQ-032 While rst_n=0: all FSMs are in OK, runs and counters are 0, and viol, alarm and any_alarm are 0, asynchronously.
REQ-033 Reset asserted mid-run discards partial runs; the first sample after release is evaluated from OK.

Structure
REQ-034 Package range_monitor_pkg holds the FSM state enum (OK=0, WARN=1, ALARM=2, 2-bit encoding) and the in_range function.
REQ-035 Sub-module range_monitor_chan implements one channel (compare, FSM, counter, viol); the top generates CHANNELS instances and the readout mux.

Verification
REQ-036 Defaults: channel 0 receives 50, 150, -101, 200 back-to-back -> viol0 = 0,1,1,1 one cycle later, alarm0 rises after the sample edge of 200, and rd_sel=0 gives rd_count=3.
REQ-037 Exclusion boundaries: samples 9, 10, 19, 20, -100, 100 -> only 10 and 19 violate.
REQ-038 Hysteresis: from ALARM, samples 0, 200, 0, 0 -> alarm stays 1 through the third sample and drops after the fourth.
REQ-039 CNT_W=2: five violations -> rd_count saturates at 3.
REQ-040 clr asserted together with a violating valid sample -> viol stays 0, counter is 0, FSM is OK; rst_n pulsed low mid-WARN -> outputs clear immediately.
REQ-041 CHANNELS=4 with all channels valid and channel 3 violating -> only viol[3] asserts; rd_sel=3 gives 1 and rd_sel=1 gives 0.

Source files
------------

// File: rtl/range_monitor_pkg.sv
// Shared types and helpers for the range monitor.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
//
// Contents:
//   state_t  - per-channel supervision state, 2-bit encoding OK=0, WARN=1, ALARM=2
//   RUN_W    - width of the consecutive-run counters (THRESH and CLEAR are at most 15)
//   in_range - signed window test with an optional half-open exclusion hole
package range_monitor_pkg;

  typedef enum logic [1:0] {
    OK    = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam int RUN_W = 4;

  // All operands are sign-extended to 32 bits by the caller.
  // An empty exclusion window (ex_lo == ex_hi) never matches, so it excludes nothing.
  function automatic logic in_range(input logic signed [31:0] x,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi,
                                    input logic signed [31:0] ex_lo,
                                    input logic signed [31:0] ex_hi);
    return (x >= lo) && (x <= hi) && !((x >= ex_lo) && (x < ex_hi));
  endfunction

endpackage

// File: rtl/range_monitor_if.sv
// Bus bundle between a sample source / status reader and range_monitor.
// Latency: n/a (wires only).
// Backpressure: none; samples are accepted every cycle they are strobed.
//
// Signals:
//   in_valid[CHANNELS], in_data[CHANNELS*WIDTH], clr, rd_sel  - source -> monitor
//   rd_count[CNT_W], viol[CHANNELS], alarm[CHANNELS], any_alarm - monitor -> source
interface range_monitor_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      clr;
  logic [SEL_W-1:0]          rd_sel;
  logic [CNT_W-1:0]          rd_count;
  logic [CHANNELS-1:0]       viol;
  logic [CHANNELS-1:0]       alarm;
  logic                      any_alarm;

  modport master (
    output in_valid, in_data, clr, rd_sel,
    input  rd_count, viol, alarm, any_alarm
  );

  modport slave (
    input  in_valid, in_data, clr, rd_sel,
    output rd_count, viol, alarm, any_alarm
  );
endinterface

// File: rtl/range_monitor_chan.sv
// One monitor channel: range compare, OK/WARN/ALARM supervisor, saturating violation counter.
// Latency: 1 cycle from sample edge to viol/alarm; counter updates on the sample edge.
// Backpressure: none; a cycle without i_valid holds all state.
//
// Ports: clk, rst_n (async, active-low), i_valid, i_data (signed sample), i_clr (sync clear),
//        o_count (violation count), o_viol (one-cycle pulse), o_alarm (level).
module range_monitor_chan
  import range_monitor_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LO     = -100,
  parameter int HI     = 100,
  parameter int EX_LO  = 10,
  parameter int EX_HI  = 20,
  parameter int THRESH = 3,
  parameter int CLEAR  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  input  logic                    i_clr,
  output logic [CNT_W-1:0]        o_count,
  output logic                    o_viol,
  output logic                    o_alarm
);

  state_t             r_state;
  logic [RUN_W-1:0]   r_bad_run;
  logic [RUN_W-1:0]   r_good_run;
  logic [CNT_W-1:0]   r_count;
  logic               r_viol;
  logic               r_alarm;

  logic signed [31:0] w_x;
  logic               w_bad;
  logic [RUN_W-1:0]   w_bad_inc;
  logic [RUN_W-1:0]   w_good_inc;

  assign w_x        = 32'(i_data);  // sign-extends: i_data is signed
  assign w_bad      = i_valid && !in_range(w_x, LO, HI, EX_LO, EX_HI);
  assign w_bad_inc  = r_bad_run + RUN_W'(1);
  assign w_good_inc = r_good_run + RUN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= OK;
      r_bad_run  <= '0;
      r_good_run <= '0;
      r_count    <= '0;
      r_viol     <= 1'b0;
      r_alarm    <= 1'b0;
    end else if (i_clr) begin
      // Clear wins over a sample arriving in the same cycle.
      r_state    <= OK;
      r_bad_run  <= '0;
      r_good_run <= '0;
      r_count    <= '0;
      r_viol     <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_viol <= w_bad;
      if (i_valid) begin
        if (w_bad && (r_count != '1)) r_count <= r_count + CNT_W'(1);
        case (r_state)
          OK: begin
            if (w_bad) begin
              if (THRESH == 1) begin
                r_state <= ALARM;
                r_alarm <= 1'b1;
              end else begin
                r_state   <= WARN;
                r_bad_run <= RUN_W'(1);
              end
            end
          end
          WARN: begin
            if (w_bad) begin
              if (w_bad_inc >= RUN_W'(THRESH)) begin
                r_state   <= ALARM;
                r_alarm   <= 1'b1;
                r_bad_run <= '0;
              end else begin
                r_bad_run <= w_bad_inc;
              end
            end else begin
              r_state   <= OK;
              r_bad_run <= '0;
            end
          end
          ALARM: begin
            // Any violation restarts the clean-run requirement.
            if (w_bad) begin
              r_good_run <= '0;
            end else if (w_good_inc >= RUN_W'(CLEAR)) begin
              r_state    <= OK;
              r_alarm    <= 1'b0;
              r_good_run <= '0;
            end else begin
              r_good_run <= w_good_inc;
            end
          end
          default: begin
            r_state    <= OK;
            r_alarm    <= 1'b0;
            r_bad_run  <= '0;
            r_good_run <= '0;
          end
        endcase
      end
    end
  end

  assign o_count = r_count;
  assign o_viol  = r_viol;
  assign o_alarm = r_alarm;

endmodule

// File: rtl/range_monitor.sv
// Multi-channel signed range monitor with per-channel alarm hysteresis and violation counters.
// Latency: 1 cycle sample-to-viol/alarm/any_alarm; rd_count is combinational from rd_sel.
// Backpressure: none; all channels accept a sample every cycle.
//
// Ports: clk, rst_n (async, active-low), bus (range_monitor_if.slave: in_valid, in_data, clr,
//        rd_sel in; rd_count, viol, alarm, any_alarm out).
module range_monitor
  import range_monitor_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int LO       = -100,
  parameter int HI       = 100,
  parameter int EX_LO    = 10,
  parameter int EX_HI    = 20,
  parameter int THRESH   = 3,
  parameter int CLEAR    = 2,
  parameter int CNT_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  range_monitor_if.slave bus
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CNT_W-1:0]    w_cnt [CHANNELS];
  logic [CHANNELS-1:0] w_viol;
  logic [CHANNELS-1:0] w_alarm;
  logic [CNT_W-1:0]    w_rd_count;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    range_monitor_chan #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI),
      .EX_LO (EX_LO),
      .EX_HI (EX_HI),
      .THRESH(THRESH),
      .CLEAR (CLEAR),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(bus.in_valid[g]),
      .i_data (bus.in_data[g*WIDTH +: WIDTH]),
      .i_clr  (bus.clr),
      .o_count(w_cnt[g]),
      .o_viol (w_viol[g]),
      .o_alarm(w_alarm[g])
    );
  end

  // Selects that name no channel fall through to zero.
  always_comb begin
    w_rd_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) w_rd_count = w_cnt[i];
    end
  end

  assign bus.rd_count  = w_rd_count;
  assign bus.viol      = w_viol;
  assign bus.alarm     = w_alarm;
  // OR of the registered alarm levels: changes on the same edge as alarm itself.
  assign bus.any_alarm = |w_alarm;

endmodule

// File: tb/tb_range_monitor.sv
module tb_range_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  range_monitor_if #(.WIDTH(16), .CHANNELS(4), .CNT_W(8)) ifa ();
  range_monitor_if #(.WIDTH(16), .CHANNELS(1), .CNT_W(2)) ifb ();

  range_monitor #(.WIDTH(16), .CHANNELS(4), .CNT_W(8)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  range_monitor #(.WIDTH(16), .CHANNELS(1), .CNT_W(2)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] viol;
    logic [3:0] alarm;
  } exp_a_t;

  typedef struct packed {
    logic viol;
    logic alarm;
    logic [1:0] count;
  } exp_b_t;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];

  // Independent reference for the default window [-100,100] minus [10,20).
  function automatic logic tb_bad(input int x);
    return (x < -100) || (x > 100) || ((x >= 10) && (x < 20));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input string tag, input logic [3:0] vld, input int d0, input int d1,
                        input int d2, input int d3, input logic c, input logic [3:0] ea);
    exp_a_t e;
    exp_a_t got;
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    e.viol = '0;
    for (int k = 0; k < 4; k++)
      if (vld[k] && !c && tb_bad(d[k])) e.viol[k] = 1'b1;
    e.alarm = ea;
    sb_a.push_back(e);
    @(negedge clk);
    ifa.in_valid = vld;
    ifa.clr      = c;
    for (int k = 0; k < 4; k++) ifa.in_data[k*16 +: 16] = 16'(d[k]);
    @(posedge clk);
    #1;
    got = sb_a.pop_front();
    chk({tag, ".viol"}, 32'(ifa.viol), 32'(got.viol));
    chk({tag, ".alarm"}, 32'(ifa.alarm), 32'(got.alarm));
    chk({tag, ".any"}, 32'(ifa.any_alarm), 32'(|got.alarm));
    ifa.in_valid = '0;
    ifa.clr      = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [1:0] sel, input int exp);
    ifa.rd_sel = sel;
    #1;
    chk(tag, 32'(ifa.rd_count), 32'(exp));
  endtask

  task automatic send_b(input string tag, input int d, input logic ea, input logic [1:0] ec);
    exp_b_t e;
    exp_b_t got;
    e.viol  = tb_bad(d);
    e.alarm = ea;
    e.count = ec;
    sb_b.push_back(e);
    @(negedge clk);
    ifb.in_valid = 1'b1;
    ifb.in_data  = 16'(d);
    ifb.rd_sel   = 1'b0;
    @(posedge clk);
    #1;
    got = sb_b.pop_front();
    chk({tag, ".viol"}, 32'(ifb.viol), 32'(got.viol));
    chk({tag, ".alarm"}, 32'(ifb.alarm), 32'(got.alarm));
    chk({tag, ".count"}, 32'(ifb.rd_count), 32'(got.count));
    ifb.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    ifa.in_valid = '0;
    ifa.in_data  = '0;
    ifa.clr      = 1'b0;
    ifa.rd_sel   = '0;
    ifb.in_valid = '0;
    ifb.in_data  = '0;
    ifb.clr      = 1'b0;
    ifb.rd_sel   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.viol", 32'(ifa.viol), 32'h0);
    chk("rst.alarm", 32'(ifa.alarm), 32'h0);
    chk("rst.any", 32'(ifa.any_alarm), 32'h0);
    chk("rst.count", 32'(ifa.rd_count), 32'h0);
    chk("rst.b_count", 32'(ifb.rd_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sequence on channel 0: alarm after the third consecutive violation
    send_a("seq50",  4'b0001, 50,   0, 0, 0, 1'b0, 4'b0000);
    send_a("seq150", 4'b0001, 150,  0, 0, 0, 1'b0, 4'b0000);
    send_a("seqm101",4'b0001, -101, 0, 0, 0, 1'b0, 4'b0000);
    send_a("seq200", 4'b0001, 200,  0, 0, 0, 1'b0, 4'b0001);
    rd_a("seq.cnt0", 2'd0, 3);

    // Hysteresis: a violation restarts the clean run
    send_a("hys0a",  4'b0001, 0,   0, 0, 0, 1'b0, 4'b0001);
    send_a("hys200", 4'b0001, 200, 0, 0, 0, 1'b0, 4'b0001);
    send_a("hys0b",  4'b0001, 0,   0, 0, 0, 1'b0, 4'b0001);
    send_a("hys0c",  4'b0001, 0,   0, 0, 0, 1'b0, 4'b0000);
    rd_a("hys.cnt0", 2'd0, 4);

    // Idle cycle holds everything
    send_a("idle", 4'b0000, 500, 500, 500, 500, 1'b0, 4'b0000);
    rd_a("idle.cnt0", 2'd0, 4);

    // Exclusion and outer boundaries on channel 1
    send_a("ex9",    4'b0010, 0, 9,    0, 0, 1'b0, 4'b0000);
    send_a("ex10",   4'b0010, 0, 10,   0, 0, 1'b0, 4'b0000);
    send_a("ex19",   4'b0010, 0, 19,   0, 0, 1'b0, 4'b0000);
    send_a("ex20",   4'b0010, 0, 20,   0, 0, 1'b0, 4'b0000);
    send_a("exm100", 4'b0010, 0, -100, 0, 0, 1'b0, 4'b0000);
    send_a("ex100",  4'b0010, 0, 100,  0, 0, 1'b0, 4'b0000);
    rd_a("ex.cnt1", 2'd1, 2);

    // Channel 2 into ALARM, then clear alongside violating samples
    send_a("c2a", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0000);
    send_a("c2b", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0000);
    send_a("c2c", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0100);
    send_a("clr", 4'b0101, 150, 0, 500, 0, 1'b1, 4'b0000);
    rd_a("clr.cnt0", 2'd0, 0);
    rd_a("clr.cnt1", 2'd1, 0);
    rd_a("clr.cnt2", 2'd2, 0);
    send_a("pc2a", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0000);
    send_a("pc2b", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0000);

    // Channel 3 two violations deep, then asynchronous reset mid-cycle
    send_a("w3a", 4'b1000, 0, 0, 0, -200, 1'b0, 4'b0000);
    send_a("w3b", 4'b1000, 0, 0, 0, -200, 1'b0, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.viol", 32'(ifa.viol), 32'h0);
    chk("arst.alarm", 32'(ifa.alarm), 32'h0);
    chk("arst.any", 32'(ifa.any_alarm), 32'h0);
    rd_a("arst.cnt3", 2'd3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All channels valid, only channel 3 out of range; partial runs were discarded
    send_a("all", 4'b1111, 0, -50, 100, -101, 1'b0, 4'b0000);
    rd_a("all.cnt3", 2'd3, 1);
    rd_a("all.cnt1", 2'd1, 0);
    send_a("post3", 4'b1000, 0, 0, 0, -101, 1'b0, 4'b0000);
    send_a("post2", 4'b0100, 0, 0, 500, 0, 1'b0, 4'b0000);

    // Narrow counter saturates without wrapping
    send_b("sat1", 300, 1'b0, 2'd1);
    send_b("sat2", 300, 1'b0, 2'd2);
    send_b("sat3", 300, 1'b1, 2'd3);
    send_b("sat4", 300, 1'b1, 2'd3);
    send_b("sat5", 300, 1'b1, 2'd3);
    ifb.rd_sel = 1'b1;
    #1;
    chk("b.selrange", 32'(ifb.rd_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
